// File: rtl/eth_rx_fcs.sv
// Ethernet receive FCS checker: CRC-32 residue check, frame length measurement,
// and 4-byte delay line that strips the trailing FCS from the payload stream.
`timescale 1ns/1ps
module eth_rx_fcs #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_eop,
    output logic [7:0]  data,
    output logic        valid,
    output logic        sop,
    output logic        eop,
    output logic        crc_ok,
    output logic        len_ok,
    output logic [10:0] length
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
    localparam logic [10:0] CNT_MAX     = 11'd2047;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PASS = 2'd2,
        DONE = 2'd3
    } state_t;

    // Reflected CRC-32, one byte processed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] byte_in);
        logic [31:0] c;
        c = crc_in ^ {24'd0, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_r;
    logic [31:0] crc_r;
    logic [7:0]  dly_r [4];
    logic [2:0]  fill_r;
    logic [10:0] cnt_r;
    logic        sop_pend_r;
    logic [31:0] crc_next_s;
    logic        len_ok_s;
    logic        crc_ok_s;

    // Next CRC value and end-of-frame status terms.
    always_comb begin
        crc_next_s = crc32_byte(crc_r, rx_data);
        len_ok_s   = (cnt_r >= MIN_LEN_C) && (cnt_r <= MAX_LEN_C);
        // A runt never filled the delay line, so it cannot carry a valid FCS.
        crc_ok_s   = (fill_r == 3'd4) && (crc_r == CRC_RESIDUE);
    end

    // Frame FSM, CRC, delay line, byte counter and registered outputs.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_r    <= IDLE;
            crc_r      <= CRC_INIT;
            fill_r     <= 3'd0;
            cnt_r      <= 11'd0;
            sop_pend_r <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                dly_r[i] <= 8'd0;
            end
            data   <= 8'd0;
            valid  <= 1'b0;
            sop    <= 1'b0;
            eop    <= 1'b0;
            crc_ok <= 1'b0;
            len_ok <= 1'b0;
            length <= 11'd0;
        end else begin
            valid  <= 1'b0;
            sop    <= 1'b0;
            eop    <= 1'b0;
            crc_ok <= 1'b0;
            len_ok <= 1'b0;
            length <= 11'd0;
            if (rx_eop) begin
                // Frame state is cleared on entry to DONE so a byte arriving
                // during DONE already starts the next frame.
                eop        <= 1'b1;
                crc_ok     <= crc_ok_s;
                len_ok     <= len_ok_s;
                length     <= cnt_r;
                crc_r      <= CRC_INIT;
                fill_r     <= 3'd0;
                cnt_r      <= 11'd0;
                sop_pend_r <= 1'b1;
                state_r    <= DONE;
            end else if (rx_valid) begin
                crc_r    <= crc_next_s;
                dly_r[0] <= rx_data;
                dly_r[1] <= dly_r[0];
                dly_r[2] <= dly_r[1];
                dly_r[3] <= dly_r[2];
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + 11'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
                if (fill_r == 3'd4) begin
                    data       <= dly_r[3];
                    valid      <= 1'b1;
                    sop        <= sop_pend_r;
                    sop_pend_r <= 1'b0;
                    state_r    <= PASS;
                end else begin
                    fill_r  <= fill_r + 3'd1;
                    state_r <= (fill_r == 3'd3) ? PASS : FILL;
                end
            end else begin
                case (state_r)
                    DONE:    state_r <= IDLE;
                    IDLE:    state_r <= IDLE;
                    FILL:    state_r <= FILL;
                    PASS:    state_r <= PASS;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule
